// File: rtl/alarm_reader_module.sv
// Alarm reader: picks today's stored alarm, rings on a minute match, times out
// after RING_MAX_MIN minutes, and optionally snoozes for SNOOZE_MIN minutes.
// Optional feature: define ALARM_SNOOZE_EN to build the SNOOZE state and Snz handling.
module alarm_reader_module #(
    parameter int unsigned SNOOZE_MIN   = 9,
    parameter int unsigned RING_MAX_MIN = 5
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [12:0] Q_r0,
    input  logic [12:0] Q_r1,
    input  logic [12:0] Q_r2,
    input  logic [12:0] Q_r3,
    input  logic [12:0] Q_r4,
    input  logic [12:0] Q_r5,
    input  logic [12:0] Q_r6,
    input  logic [2:0]  Day,
    input  logic [4:0]  Hour,
    input  logic [5:0]  Minute,
    input  logic        Min_tick,
    input  logic        Ack,
    input  logic        Snz,
    output logic        Alarm,
    output logic        Snoozing,
    output logic [2:0]  Ring_day
);

    typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

    localparam logic [3:0] RingLoad   = 4'(RING_MAX_MIN);

    state_e      state_q, state_d;
    logic [3:0]  ring_cnt_q, ring_cnt_d;
    logic [2:0]  ring_day_q, ring_day_d;
    logic        alarm_q;
    logic [12:0] sel;
    logic        match;

    // Day mux; Day=7 selects an all-zero entry so it can never match.
    always_comb begin
        sel = 13'd0;
        case (Day)
            3'd0:    sel = Q_r0;
            3'd1:    sel = Q_r1;
            3'd2:    sel = Q_r2;
            3'd3:    sel = Q_r3;
            3'd4:    sel = Q_r4;
            3'd5:    sel = Q_r5;
            3'd6:    sel = Q_r6;
            default: sel = 13'd0;
        endcase
    end

    assign match = Min_tick & sel[12] & (sel[11:7] == Hour) & (sel[6:1] == Minute);

`ifdef ALARM_SNOOZE_EN
    localparam logic [3:0] SnoozeLoad = 4'(SNOOZE_MIN);

    logic [3:0] snz_cnt_q, snz_cnt_d;
    logic       snoozing_q;
`endif

    // Next-state, counter and ring-day logic.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        ring_day_d = ring_day_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (match) begin
                    state_d    = StRing;
                    ring_cnt_d = RingLoad;
                    ring_day_d = Day;
                end
            end
            StRing: begin
                if (Ack) begin
                    state_d = StIdle;
`ifdef ALARM_SNOOZE_EN
                end else if (Snz) begin
                    state_d   = StSnooze;
                    snz_cnt_d = SnoozeLoad;
`endif
                end else if (Min_tick) begin
                    // Match while ringing is deliberately ignored: no reload.
                    if (ring_cnt_q <= 4'd1) begin
                        ring_cnt_d = 4'd0;
                        state_d    = StIdle;
                    end else begin
                        ring_cnt_d = ring_cnt_q - 4'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            StSnooze: begin
                if (Ack) begin
                    state_d = StIdle;
                end else if (match) begin
                    // A fresh alarm cuts the snooze short and takes over Ring_day.
                    state_d    = StRing;
                    ring_cnt_d = RingLoad;
                    ring_day_d = Day;
                    snz_cnt_d  = 4'd0;
                end else if (Min_tick) begin
                    if (snz_cnt_q <= 4'd1) begin
                        snz_cnt_d  = 4'd0;
                        state_d    = StRing;
                        ring_cnt_d = RingLoad;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 4'd1;
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= StIdle;
            ring_cnt_q <= 4'd0;
            ring_day_q <= 3'd0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            ring_day_q <= ring_day_d;
            alarm_q    <= (state_d == StRing);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze counter and registered Snoozing flag.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            snz_cnt_q  <= 4'd0;
            snoozing_q <= 1'b0;
        end else begin
            snz_cnt_q  <= snz_cnt_d;
            snoozing_q <= (state_d == StSnooze);
        end
    end

    assign Snoozing = snoozing_q;

    logic unused_bits;
    assign unused_bits = ^{sel[0], Q_r0[0], Q_r1[0], Q_r2[0], Q_r3[0], Q_r4[0], Q_r5[0],
                           Q_r6[0]};
`else
    assign Snoozing = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{Snz, sel[0], Q_r0[0], Q_r1[0], Q_r2[0], Q_r3[0], Q_r4[0], Q_r5[0],
                           Q_r6[0]};
`endif

    assign Alarm    = alarm_q;
    assign Ring_day = ring_day_q;

endmodule

// File: doc/alarm_reader_module.md
ALARM_READER_MODULE -- requirements
Module: alarm_reader_module

Interface
REQ-001 Parameter: SNOOZE_MIN, 9, snooze length in minutes, legal range 1..15.
REQ-002 Parameter: RING_MAX_MIN, 5, minutes an unacknowledged alarm rings before it stops on its own, legal range 1..15.
REQ-003 Port: Clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: Clr  input  1  reset, asynchronous, active-high.
REQ-005 Ports: Q_r0..Q_r6  input  13 each  stored day alarms, Sunday..Saturday; [12]=enable, [11:7]=hour 0-23, [6:1]=minute 0-59, [0]=reserved, ignored.
REQ-006 Port: Day  input  3  current day, 0=Sunday..6=Saturday; 7 is invalid.
REQ-007 Port: Hour  input  5  current hour, 0-23.
REQ-008 Port: Minute  input  6  current minute, 0-59.
REQ-009 Port: Min_tick  input  1  one-cycle pulse in the cycle Hour/Minute first show a new minute.
REQ-010 Port: Ack  input  1  level; stop alarm.
REQ-011 Port: Snz  input  1  level; snooze alarm.
REQ-012 Port: Alarm  output  1  buzzer drive; high in RING.
REQ-013 Port: Snoozing  output  1  high in SNOOZE.
REQ-014 Port: Ring_day  output  3  day whose entry fired last; held until next fire.

Function
REQ-015 Day mux: Day selects Q_r[Day]; Day=7 selects nothing, match forced 0.
REQ-016 Match = Min_tick & sel[12] & (sel[11:7]==Hour) & (sel[6:1]==Minute); evaluated only in cycles with Min_tick=1.
REQ-017 FSM states IDLE, RING, SNOOZE; registered outputs; Alarm/Snoozing reflect state one cycle after the causing event.
REQ-018 IDLE: Match -> RING; ring-minute counter loaded to RING_MAX_MIN; Ring_day <= Day.
REQ-019 RING: Ack=1 -> IDLE (priority over Snz, Min_tick, Match).
REQ-020 RING: Snz=1 & Ack=0 -> SNOOZE; snooze counter loaded to SNOOZE_MIN.
REQ-021 RING: Min_tick with no Ack/Snz -> ring counter decrements; on reaching 0 -> IDLE; Match in RING is ignored (no counter reload).
REQ-022 SNOOZE: Ack=1 -> IDLE (cancels snooze); Snz ignored.
REQ-023 SNOOZE: Min_tick -> snooze counter decrements; at 0 -> RING with ring counter reloaded; a Match in the same cycle also -> RING, Ring_day <= Day; Match alone in SNOOZE -> RING, snooze cleared.
REQ-024 Counters 4 bits, count down, never wrap below 0.
REQ-025 Ack/Snz are levels: Snz held through return to RING re-snoozes on the next cycle; holding Ack keeps FSM in IDLE only via RING/SNOOZE exit, no effect in IDLE.
REQ-026 Register inputs Q_r0..Q_r6 are read combinationally; a register change takes effect at the next Min_tick.

Reset
REQ-027 Clr=1 at any time, including mid-RING or mid-SNOOZE: state IDLE, Alarm=0, Snoozing=0, Ring_day=0, both counters 0, asynchronously.
REQ-028 First Min_tick after Clr deassertion is evaluated normally.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN defined: SNOOZE state, snooze counter, Snz input behaviour as above.
REQ-030 ALARM_SNOOZE_EN undefined: no SNOOZE state or counter; Snz ignored; Snoozing tied 0; all other behaviour unchanged.

Verification
REQ-031 Q_r2=1_07_1E_0 (en, 07:30), Day=2, Hour=7, Minute=30, Min_tick pulse -> Alarm=1 next cycle, Ring_day=2.
REQ-032 Same entry with enable bit 0, or Day=7 -> Alarm stays 0.
REQ-033 Ringing, Ack and Snz both 1 -> IDLE next cycle, Alarm=0, Snoozing=0.
REQ-034 Ringing, Snz pulse -> Snoozing=1, Alarm=0; 9 Min_ticks -> Alarm=1 after 9th; undefined ALARM_SNOOZE_EN -> Snz no effect.
REQ-035 Ringing, no input, 5 Min_ticks -> Alarm=0 after 5th; 4 Min_ticks -> still 1.
REQ-036 Clr pulse asynchronous mid-SNOOZE (between clock edges) -> Alarm=0, Snoozing=0 immediately; later Min_ticks without Match keep Alarm=0.
